// File: rtl/uart_pkt_pkg.sv
// Shared constants and types for the UART packet controller.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package uart_pkt_pkg;

    localparam logic [7:0] SOF_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHK     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_CHK  = 2'd0,
        ERR_LINE = 2'd1,
        ERR_LEN  = 2'd2,
        ERR_TMO  = 2'd3
    } err_code_t;

    // A LEN byte is legal when it is non-zero and no larger than the configured maximum.
    function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max_len);
        return (len != 8'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/uart_pkt_fifo.sv
// Payload byte FIFO with speculative write pointer, commit and rollback.
// Latency: committed head is visible the cycle after commit (registered-RAM first-word-fall-through).
// Backpressure: pop only when o_valid; push ignored when full; o_full uses the pre-pop read pointer.
module uart_pkt_fifo #(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_push_last,
    input  logic       i_commit,
    input  logic       i_rollback,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_last
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_wr_spec;
    logic [AW:0]  r_wr_commit;
    logic [7:0]   r_mem_dat [DEPTH];
    logic         r_mem_last [DEPTH];
    logic [7:0]   r_rd_dat;
    logic         r_rd_last;

    logic         w_pop;
    logic         w_wr_en;
    logic [AW:0]  w_rd_nxt;

    // Only committed bytes are visible to the consumer.
    assign o_valid  = (r_rd_ptr != r_wr_commit);
    assign o_full   = (r_wr_spec[AW] != r_rd_ptr[AW]) &&
                      (r_wr_spec[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = o_valid & i_pop;
    assign w_wr_en  = i_push & ~o_full;
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // Pointer bookkeeping: pop, speculative push, rollback and commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            if (i_rollback) begin
                r_wr_spec <= r_wr_commit;
            end else if (w_wr_en) begin
                r_wr_spec <= r_wr_spec + 1'b1;
            end
            if (i_commit) begin
                r_wr_commit <= r_wr_spec;
            end
        end
    end

    // Storage array; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_dat[r_wr_spec[AW-1:0]]  <= i_push_data;
            r_mem_last[r_wr_spec[AW-1:0]] <= i_push_last;
        end
    end

    // Registered head read at the next read address, bypassing a same-cycle write to that slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dat  <= 8'd0;
            r_rd_last <= 1'b0;
        end else if (w_wr_en && (r_wr_spec[AW-1:0] == w_rd_nxt[AW-1:0])) begin
            r_rd_dat  <= i_push_data;
            r_rd_last <= i_push_last;
        end else begin
            r_rd_dat  <= r_mem_dat[w_rd_nxt[AW-1:0]];
            r_rd_last <= r_mem_last[w_rd_nxt[AW-1:0]];
        end
    end

    assign o_data = r_rd_dat;
    assign o_last = r_rd_last;

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames the uartrx byte stream (A5, LEN, payload, CHK) into packets; optional stats via UART_PKT_STATS_EN.
// Latency: pkt_ok/pkt_err one cycle after the deciding accept; committed payload visible with pkt_ok.
// Backpressure: out_valid/out_ready on committed bytes; a full buffer drops the incoming packet (code 2).
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int FIFO_DEPTH  = 32,
    parameter int TIMEOUT_CYC = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdsig,
    input  logic        rx_dataerror,
    input  logic        rx_frameerror,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [1:0]  err_code
`ifdef UART_PKT_STATS_EN
    ,
    output logic [15:0] pkt_good_cnt,
    output logic [15:0] pkt_bad_cnt
`endif
);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rdsig_d;
    logic [7:0]  r_remain;
    logic [7:0]  w_remain_nxt;
    logic [7:0]  r_chk;
    logic [7:0]  w_chk_nxt;
    logic [TW-1:0] r_tmo_cnt;
    logic        r_pkt_ok;
    logic        r_pkt_err;
    err_code_t   r_err_code;

    logic        w_accept;
    logic        w_line_err;
    logic        w_expire;
    logic        w_full;
    logic        w_push;
    logic        w_push_last;
    logic        w_commit;
    logic        w_rollback;
    logic        w_ok_nxt;
    logic        w_err_nxt;
    err_code_t   w_code_nxt;

    // uartrx holds data and flags stable when rdsig falls, so that edge is the sample point.
    assign w_accept   = r_rdsig_d & ~rx_rdsig;
    assign w_line_err = rx_dataerror | rx_frameerror;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_expire   = (r_state != IDLE) && !w_accept && (r_tmo_cnt == TMO_LAST);

    // Next-state, checksum/length tracking and FIFO control for the packet framer.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_chk_nxt    = r_chk;
        w_push       = 1'b0;
        w_push_last  = 1'b0;
        w_commit     = 1'b0;
        w_rollback   = 1'b0;
        w_ok_nxt     = 1'b0;
        w_err_nxt    = 1'b0;
        w_code_nxt   = ERR_CHK;

        case (r_state)
            IDLE: begin
                if (w_accept && !w_line_err && (rx_data == SOF_BYTE)) begin
                    w_state_nxt = LEN;
                end
            end

            LEN: begin
                if (w_accept) begin
                    if (w_line_err) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_LINE;
                    end else if (!len_ok(rx_data, MAX_LEN_B)) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_LEN;
                    end else begin
                        w_remain_nxt = rx_data;
                        w_chk_nxt    = rx_data;
                        w_state_nxt  = PAYLOAD;
                    end
                end else if (w_expire) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = ERR_TMO;
                end
            end

            PAYLOAD: begin
                if (w_accept) begin
                    if (w_line_err) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_LINE;
                    end else if (w_full) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_LEN;
                    end else begin
                        // The final payload byte carries the last tag; it only becomes visible on commit.
                        w_push       = 1'b1;
                        w_push_last  = (r_remain == 8'd1);
                        w_chk_nxt    = r_chk ^ rx_data;
                        w_remain_nxt = r_remain - 8'd1;
                        if (r_remain == 8'd1) begin
                            w_state_nxt = CHK;
                        end
                    end
                end else if (w_expire) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = ERR_TMO;
                end
            end

            CHK: begin
                if (w_accept) begin
                    if (w_line_err) begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_LINE;
                    end else if (rx_data == r_chk) begin
                        w_commit    = 1'b1;
                        w_ok_nxt    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt  = 1'b1;
                        w_code_nxt = ERR_CHK;
                    end
                end else if (w_expire) begin
                    w_err_nxt  = 1'b1;
                    w_code_nxt = ERR_TMO;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Every abort discards the speculative bytes of the current packet.
        if (w_err_nxt) begin
            w_rollback  = 1'b1;
            w_state_nxt = IDLE;
        end
    end

    // State, framing registers, edge-detect flop and registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rdsig_d  <= 1'b0;
            r_remain   <= 8'd0;
            r_chk      <= 8'd0;
            r_pkt_ok   <= 1'b0;
            r_pkt_err  <= 1'b0;
            r_err_code <= ERR_CHK;
        end else begin
            r_state    <= w_state_nxt;
            r_rdsig_d  <= rx_rdsig;
            r_remain   <= w_remain_nxt;
            r_chk      <= w_chk_nxt;
            r_pkt_ok   <= w_ok_nxt;
            r_pkt_err  <= w_err_nxt;
            r_err_code <= w_code_nxt;
        end
    end

    // Inter-byte timer: idle-held at zero, cleared on each accepted byte and when the packet ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept || (r_state == IDLE) || (w_state_nxt == IDLE)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    uart_pkt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (rx_data),
        .i_push_last (w_push_last),
        .i_commit    (w_commit),
        .i_rollback  (w_rollback),
        .i_pop       (out_ready),
        .o_full      (w_full),
        .o_valid     (out_valid),
        .o_data      (out_data),
        .o_last      (out_last)
    );

    assign pkt_ok   = r_pkt_ok;
    assign pkt_err  = r_pkt_err;
    assign err_code = r_err_code;

`ifdef UART_PKT_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    // Saturating packet outcome counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            if (r_pkt_ok && (r_good_cnt != 16'hFFFF)) begin
                r_good_cnt <= r_good_cnt + 16'd1;
            end
            if (r_pkt_err && (r_bad_cnt != 16'hFFFF)) begin
                r_bad_cnt <= r_bad_cnt + 16'd1;
            end
        end
    end

    assign pkt_good_cnt = r_good_cnt;
    assign pkt_bad_cnt  = r_bad_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboard bench for uart_rx_pkt_ctrl: directed packets, expected events/bytes queued at stimulus time.
// Latency: events checked for type/code, timeout event also checked for exact cycle.
// Backpressure: out_ready toggled to hold committed data and to fill the buffer.
module tb_uart_rx_pkt_ctrl;

    localparam int TIMEOUT_CYC = 2048;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_rdsig = 1'b0;
    logic       rx_dataerror = 1'b0;
    logic       rx_frameerror = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        int         cyc;
    } evt_t;

    evt_t       evq[$];
    logic [8:0] byq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         last_acc = 0;
    logic       chk_reset = 1'b0;
    logic       do_final = 1'b0;
    logic       final_done = 1'b0;

    uart_rx_pkt_ctrl #(
        .MAX_LEN     (16),
        .FIFO_DEPTH  (32),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_rdsig      (rx_rdsig),
        .rx_dataerror  (rx_dataerror),
        .rx_frameerror (rx_frameerror),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pkt_ok        (pkt_ok),
        .pkt_err       (pkt_err),
        .err_code      (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an event or a byte.
    initial begin
        evt_t       e;
        logic [8:0] b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (chk_reset) begin
                    check("rst_out_valid", 32'(out_valid), 32'd0);
                    check("rst_out_data",  32'(out_data),  32'd0);
                    check("rst_out_last",  32'(out_last),  32'd0);
                    check("rst_pkt_ok",    32'(pkt_ok),    32'd0);
                    check("rst_pkt_err",   32'(pkt_err),   32'd0);
                    check("rst_err_code",  32'(err_code),  32'd0);
                end
                if (pkt_ok || pkt_err) begin
                    check("evt_ok_err_exclusive", 32'(pkt_ok & pkt_err), 32'd0);
                    check("evt_expected", 32'(evq.size() > 0), 32'd1);
                    if (evq.size() > 0) begin
                        e = evq.pop_front();
                        check("evt_is_err", 32'(pkt_err), 32'(e.is_err));
                        if (e.is_err) check("evt_err_code", 32'(err_code), 32'(e.code));
                        if (e.cyc >= 0) check("evt_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
                if (out_valid && out_ready) begin
                    check("byte_expected", 32'(byq.size() > 0), 32'd1);
                    if (byq.size() > 0) begin
                        b = byq.pop_front();
                        check("out_data", 32'(out_data), 32'(b[7:0]));
                        check("out_last", 32'(out_last), 32'(b[8]));
                    end
                end
                if (do_final) begin
                    check("final_evq_empty", 32'(evq.size()), 32'd0);
                    check("final_byq_empty", 32'(byq.size()), 32'd0);
                    check("final_out_valid", 32'(out_valid), 32'd0);
                    final_done = 1'b1;
                end
            end
        end
    end

    // Called at #1 after a rising edge; the accept lands in the following cycle.
    task automatic send_byte(input logic [7:0] b, input logic perr, input logic ferr);
        rx_data       = b;
        rx_dataerror  = perr;
        rx_frameerror = ferr;
        rx_rdsig      = 1'b1;
        @(posedge clk); #1;
        rx_rdsig = 1'b0;
        last_acc = cyc;
        @(posedge clk); #1;
        rx_dataerror  = 1'b0;
        rx_frameerror = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b0, 1'b0);
    endtask

    task automatic push_evt(input logic is_err, input logic [1:0] code, input int c);
        evt_t e;
        e.is_err = is_err;
        e.code   = code;
        e.cyc    = c;
        evq.push_back(e);
    endtask

    // Payload byte i = base + i*step; chk is hand-computed by the caller.
    task automatic good_pkt(input int len, input logic [7:0] base, input logic [7:0] step,
                            input logic [7:0] chk, input logic keep);
        logic [7:0] p;
        push_evt(1'b0, 2'd0, -1);
        send(8'hA5);
        send(8'(len));
        for (int i = 0; i < len; i++) begin
            p = base + 8'(i) * step;
            if (keep) byq.push_back({(i == len - 1), p});
            send(p);
        end
        send(chk);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && (evq.size() != 0 || byq.size() != 0); i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_evt(input int max_cyc);
        for (int i = 0; i < max_cyc && evq.size() != 0; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        chk_reset = 1'b1;
        @(posedge clk); #1;
        chk_reset = 1'b0;
    endtask

    initial begin
        int t;
        @(posedge clk); #1;
        do_reset();

        // Good packet: 11 22 33, CHK 03.
        good_pkt(3, 8'h11, 8'h11, 8'h03, 1'b1);
        wait_idle(200);

        // Bad checksum (expected 32, sent 00).
        push_evt(1'b1, 2'd0, -1);
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        wait_idle(200);
        // Frame-errored SOF in IDLE is ignored, then a good one-byte packet.
        send_byte(8'hA5, 1'b0, 1'b1);
        good_pkt(1, 8'h55, 8'h00, 8'h54, 1'b1);
        wait_idle(200);

        // Committed packet held back, then a parity error on the second payload byte.
        out_ready = 1'b0;
        good_pkt(2, 8'h66, 8'h11, 8'h13, 1'b1);
        push_evt(1'b1, 2'd1, -1);
        send(8'hA5); send(8'h04); send(8'h01);
        send_byte(8'h02, 1'b1, 1'b0);
        wait_evt(200);
        out_ready = 1'b1;
        wait_idle(200);

        // Length bounds: 0 and MAX_LEN+1 rejected, MAX_LEN accepted.
        push_evt(1'b1, 2'd2, -1);
        send(8'hA5); send(8'h00);
        push_evt(1'b1, 2'd2, -1);
        send(8'hA5); send(8'h11);
        good_pkt(16, 8'h30, 8'h01, 8'h10, 1'b1);
        wait_idle(300);

        // Timeout: error exactly TIMEOUT_CYC idle cycles after the last accept, plus one for the pulse.
        send(8'hA5); send(8'h02); send(8'hAA);
        push_evt(1'b1, 2'd3, last_acc + TIMEOUT_CYC + 1);
        wait_evt(TIMEOUT_CYC + 200);

        // A byte accepted on the expiry cycle wins over the timeout.
        send(8'hA5); send(8'h02); send(8'hAA);
        t = last_acc;
        push_evt(1'b0, 2'd0, -1);
        byq.push_back({1'b0, 8'hAA});
        byq.push_back({1'b1, 8'hBB});
        while (cyc < t + TIMEOUT_CYC - 1) begin
            @(posedge clk); #1;
        end
        send(8'hBB);
        send(8'h13);
        wait_idle(200);

        // Overflow: two full packets fill the 32-byte buffer, third aborts at its first payload byte.
        out_ready = 1'b0;
        good_pkt(16, 8'h30, 8'h01, 8'h10, 1'b1);
        good_pkt(16, 8'h30, 8'h01, 8'h10, 1'b1);
        push_evt(1'b1, 2'd2, -1);
        send(8'hA5); send(8'h10); send(8'h31);
        wait_evt(200);
        out_ready = 1'b1;
        wait_idle(300);

        // Reset mid-packet discards committed data silently.
        out_ready = 1'b0;
        good_pkt(1, 8'h77, 8'h00, 8'h76, 1'b0);
        wait_evt(100);
        send(8'hA5); send(8'h02); send(8'h12);
        do_reset();
        out_ready = 1'b1;
        good_pkt(1, 8'h09, 8'h00, 8'h08, 1'b1);
        wait_idle(200);

        repeat (20) @(posedge clk);
        #1;
        do_final = 1'b1;
        for (int i = 0; i < 5 && !final_done; i++) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
